regfile_wb_arbiter: RTL and testbench



---
 rtl/rf_pkg.sv | 19 +
 rtl/wb_slot.sv | 49 ++++
 rtl/regfile_wb_arbiter.sv | 105 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared types for the register-file writeback arbiter.
// Widths, the held write request, and the source identifiers.
package rf_pkg;

    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 2 ** REG_AW;

    typedef struct packed {
        logic [REG_AW-1:0] wa;
        logic [XLEN-1:0]   wd;
    } wb_req_t;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } src_e;

endpackage

// File: rtl/wb_slot.sv
// One-entry writeback holding slot; a write accepted at an edge is visible the next cycle.
// ready_o is high when empty or when the slot is being granted (pass-through refill); x0 writes are dropped.
module wb_slot
    import rf_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    valid_i,
    output logic    ready_o,
    input  wb_req_t req_i,
    input  logic    grant_i,
    output logic    vld_o,
    output wb_req_t req_o,
    output logic    load_o
);

    logic    valid_q, valid_d;
    wb_req_t req_q, req_d;

    assign ready_o = rst_n && (!valid_q || grant_i);
    // The handshake completes for x0, but nothing is held for it.
    assign load_o  = valid_i && ready_o && (req_i.wa != '0);

    always_comb begin
        valid_d = valid_q;
        req_d   = req_q;
        if (grant_i) begin
            valid_d = 1'b0;
        end
        if (load_o) begin
            valid_d = 1'b1;
            req_d   = req_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            req_q   <= '0;
        end else begin
            valid_q <= valid_d;
            req_q   <= req_d;
        end
    end

    assign vld_o = valid_q;
    assign req_o = req_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU and LSU writebacks onto the single register-file write port, oldest first.
// A write accepted at edge N is driven during the following cycle; the losing full slot back-pressures its source.
module regfile_wb_arbiter
    import rf_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                alu_valid_i,
    output logic                alu_ready_o,
    input  logic [REG_AW-1:0]   alu_wa_i,
    input  logic [XLEN-1:0]     alu_wd_i,
    input  logic                lsu_valid_i,
    output logic                lsu_ready_o,
    input  logic [REG_AW-1:0]   lsu_wa_i,
    input  logic [XLEN-1:0]     lsu_wd_i,
    output logic                rf_we_o,
    output logic [REG_AW-1:0]   rf_wa_o,
    output logic [XLEN-1:0]     rf_wd_o,
    output logic [NUM_REGS-1:0] pend_o,
    output logic                idle_o
);

    logic    alu_vld, lsu_vld;
    logic    alu_gnt, lsu_gnt;
    logic    alu_load, lsu_load;
    wb_req_t alu_req, lsu_req;
    src_e    older_q, older_d;

    wb_slot u_alu_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (alu_valid_i),
        .ready_o (alu_ready_o),
        .req_i   ('{wa: alu_wa_i, wd: alu_wd_i}),
        .grant_i (alu_gnt),
        .vld_o   (alu_vld),
        .req_o   (alu_req),
        .load_o  (alu_load)
    );

    wb_slot u_lsu_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (lsu_valid_i),
        .ready_o (lsu_ready_o),
        .req_i   ('{wa: lsu_wa_i, wd: lsu_wd_i}),
        .grant_i (lsu_gnt),
        .vld_o   (lsu_vld),
        .req_o   (lsu_req),
        .load_o  (lsu_load)
    );

    // Grants are suppressed during reset so held writes are discarded, never written.
    always_comb begin
        alu_gnt = rst_n && alu_vld && (!lsu_vld || (older_q == SRC_ALU));
        lsu_gnt = rst_n && lsu_vld && (!alu_vld || (older_q == SRC_LSU));
    end

    // A freshly loaded slot is always the younger one; same-edge loads favour the load (LSU) as older.
    always_comb begin
        older_d = older_q;
        if (alu_load) begin
            older_d = SRC_LSU;
        end else if (lsu_load) begin
            older_d = SRC_ALU;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            older_q <= SRC_ALU;
        end else begin
            older_q <= older_d;
        end
    end

    always_comb begin
        rf_we_o = 1'b0;
        rf_wa_o = '0;
        rf_wd_o = '0;
        if (alu_gnt) begin
            rf_we_o = 1'b1;
            rf_wa_o = alu_req.wa;
            rf_wd_o = alu_req.wd;
        end else if (lsu_gnt) begin
            rf_we_o = 1'b1;
            rf_wa_o = lsu_req.wa;
            rf_wd_o = lsu_req.wd;
        end
    end

    always_comb begin
        pend_o = '0;
        if (alu_vld) begin
            pend_o[alu_req.wa] = 1'b1;
        end
        if (lsu_vld) begin
            pend_o[lsu_req.wa] = 1'b1;
        end
        pend_o[0] = 1'b0;
    end

    assign idle_o = !alu_vld && !lsu_vld;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and random writeback traffic checked against a program-order queue model.
module tb_regfile_wb_arbiter;
    import rf_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                alu_valid_i, lsu_valid_i;
    logic                alu_ready_o, lsu_ready_o;
    logic [REG_AW-1:0]   alu_wa_i, lsu_wa_i;
    logic [XLEN-1:0]     alu_wd_i, lsu_wd_i;
    logic                rf_we_o;
    logic [REG_AW-1:0]   rf_wa_o;
    logic [XLEN-1:0]     rf_wd_o;
    logic [NUM_REGS-1:0] pend_o;
    logic                idle_o;

    regfile_wb_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_valid_i (alu_valid_i),
        .alu_ready_o (alu_ready_o),
        .alu_wa_i    (alu_wa_i),
        .alu_wd_i    (alu_wd_i),
        .lsu_valid_i (lsu_valid_i),
        .lsu_ready_o (lsu_ready_o),
        .lsu_wa_i    (lsu_wa_i),
        .lsu_wd_i    (lsu_wd_i),
        .rf_we_o     (rf_we_o),
        .rf_wa_o     (rf_wa_o),
        .rf_wd_o     (rf_wd_o),
        .pend_o      (pend_o),
        .idle_o      (idle_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        src_e              src;
        logic [REG_AW-1:0] wa;
        logic [XLEN-1:0]   wd;
    } ent_t;

    // Writes not yet committed, in program order (same edge: load before ALU).
    ent_t           q[$];
    logic [XLEN-1:0] exp_rf[NUM_REGS];
    logic [XLEN-1:0] dut_rf[NUM_REGS];
    int             total = 0;
    int             bad   = 0;
    bit             alu_acc, lsu_acc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // A source can hand over when it has nothing outstanding, or its outstanding write is the next to retire.
    function automatic bit m_ready(input src_e s, input bit r);
        if (!r) return 1'b0;
        foreach (q[i]) begin
            if (q[i].src == s) return (i == 0);
        end
        return 1'b1;
    endfunction

    task automatic step(input bit r,
                        input bit av, input logic [REG_AW-1:0] aw, input logic [XLEN-1:0] ad,
                        input bit lv, input logic [REG_AW-1:0] lw, input logic [XLEN-1:0] ld);
        bit                  ar, lr, com;
        logic [NUM_REGS-1:0] ep;
        rst_n       = r;
        alu_valid_i = av;
        alu_wa_i    = aw;
        alu_wd_i    = ad;
        lsu_valid_i = lv;
        lsu_wa_i    = lw;
        lsu_wd_i    = ld;
        #1;
        ar  = m_ready(SRC_ALU, r);
        lr  = m_ready(SRC_LSU, r);
        com = r && (q.size() > 0);
        ep  = '0;
        foreach (q[i]) ep[q[i].wa] = 1'b1;
        chk("alu_ready", 64'(alu_ready_o), 64'(ar));
        chk("lsu_ready", 64'(lsu_ready_o), 64'(lr));
        chk("rf_we", 64'(rf_we_o), 64'(com));
        chk("rf_wa", 64'(rf_wa_o), com ? 64'(q[0].wa) : 64'd0);
        chk("rf_wd", 64'(rf_wd_o), com ? 64'(q[0].wd) : 64'd0);
        chk("pend", 64'(pend_o), 64'(ep));
        chk("idle", 64'(idle_o), 64'(q.size() == 0));
        if (rf_we_o) dut_rf[rf_wa_o] = rf_wd_o;
        if (com) begin
            exp_rf[q[0].wa] = q[0].wd;
            void'(q.pop_front());
        end
        alu_acc = av && ar;
        lsu_acc = lv && lr;
        if (lsu_acc && lw != '0) q.push_back('{SRC_LSU, lw, ld});
        if (alu_acc && aw != '0) q.push_back('{SRC_ALU, aw, ad});
        if (!r) q.delete();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_step();
        step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        bit                pa_v, pl_v;
        logic [REG_AW-1:0] pa_w, pl_w;
        logic [XLEN-1:0]   pa_d, pl_d;
        bit                r;
        int                tries;

        for (int i = 0; i < NUM_REGS; i++) begin
            exp_rf[i] = '0;
            dut_rf[i] = '0;
        end
        rst_n = 1'b0;
        alu_valid_i = 1'b0; alu_wa_i = '0; alu_wd_i = '0;
        lsu_valid_i = 1'b0; lsu_wa_i = '0; lsu_wd_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset held with both sources requesting.
        step(1'b0, 1'b1, 5'd5, 32'h1, 1'b1, 5'd6, 32'h2);
        step(1'b0, 1'b1, 5'd5, 32'h1, 1'b1, 5'd6, 32'h2);
        idle_step();

        // Single ALU write.
        step(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
        idle_step();
        idle_step();
        chk("x5_value", 64'(dut_rf[5]), 64'h0000_0000_DEAD_BEEF);

        // Same register from both sources on the same edge.
        step(1'b1, 1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22);
        repeat (3) idle_step();
        chk("x3_value", 64'(dut_rf[3]), 64'h11);

        // LSU write queued ahead of a later ALU write.
        step(1'b1, 1'b1, 5'd10, 32'hA0, 1'b0, '0, '0);
        step(1'b1, 1'b1, 5'd11, 32'hB0, 1'b1, 5'd7, 32'h77);
        tries = 0;
        do begin
            step(1'b1, 1'b1, 5'd9, 32'h99, 1'b0, '0, '0);
            tries++;
        end while (!alu_acc && tries < 6);
        repeat (3) idle_step();
        chk("x7_value", 64'(dut_rf[7]), 64'h77);
        chk("x9_value", 64'(dut_rf[9]), 64'h99);

        // x0 write: accepted, never held.
        step(1'b1, 1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFF);
        idle_step();
        chk("x0_value", 64'(dut_rf[0]), 64'h0);

        // Uninterrupted ALU stream.
        for (int i = 1; i <= 8; i++)
            step(1'b1, 1'b1, REG_AW'(i), 32'h1000 + 32'(i), 1'b0, '0, '0);
        repeat (2) idle_step();

        // Stream interrupted by reset.
        for (int i = 1; i <= 8; i++) begin
            r = (i != 5);
            step(r, r, REG_AW'(i), 32'h2000 + 32'(i), 1'b0, '0, '0);
        end
        repeat (2) idle_step();
        chk("x4_dropped", 64'(dut_rf[4]), 64'h1004);
        chk("x8_after_rst", 64'(dut_rf[8]), 64'h2008);

        // Random traffic with occasional resets; requests are held until accepted.
        pa_v = 1'b0; pl_v = 1'b0;
        pa_w = '0; pl_w = '0; pa_d = '0; pl_d = '0;
        for (int c = 0; c < 400; c++) begin
            if (!pa_v && $urandom_range(0, 3) != 0) begin
                pa_v = 1'b1;
                pa_w = REG_AW'($urandom_range(0, 7));
                pa_d = $urandom;
            end
            if (!pl_v && $urandom_range(0, 3) != 0) begin
                pl_v = 1'b1;
                pl_w = REG_AW'($urandom_range(0, 7));
                pl_d = $urandom;
            end
            r = ($urandom_range(0, 63) != 0);
            step(r, pa_v, pa_w, pa_d, pl_v, pl_w, pl_d);
            if (alu_acc) pa_v = 1'b0;
            if (lsu_acc) pl_v = 1'b0;
        end
        repeat (3) idle_step();

        for (int i = 0; i < NUM_REGS; i++)
            chk($sformatf("rf_x%0d", i), 64'(dut_rf[i]), 64'(exp_rf[i]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
